ps2_host_ctrl: RTL and testbench
================================

# ps2_host_ctrl

PS/2 host-side line controller that owns the keyboard clock/data pair and shares it between inbound scan-code reception and outbound host commands (e.g. 0xED set-LEDs, 0xFF reset). Sits between the open-drain pads and the scan-code decoder/display path. Received bytes go to the decoder. Command bytes from system logic are serialised using the PS/2 host-to-device protocol. The top level forms each pad as `keyb_clk = keyb_clk_oe ? 1'b0 : 1'bz` (same for data).

## Interface
- `INHIBIT_CYCLES`, 10000 — clk cycles `keyb_clk` is held low before request-to-send (100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, 2000000 — max clk cycles between device clock falling edges, or while awaiting a response, before abort.
- `clk`  in  1  system clock, 100 MHz; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `keyb_clk_in`  in  1  sampled PS/2 clock pad.
- `keyb_data_in`  in  1  sampled PS/2 data pad.
- `keyb_clk_oe`  out  1  1 = pull clock low.
- `keyb_data_oe`  out  1  1 = pull data low.
- `cmd_valid`  in  1  command byte offered.
- `cmd_byte`  in  8  command byte.
- `cmd_ready`  out  1  high only in IDLE; transfer on `cmd_valid & cmd_ready`.
- `rx_valid`  out  1  1-cycle pulse, good frame received.
- `rx_byte`  out  8  last received byte; held until next frame.
- `rx_err`  out  1  1-cycle pulse on parity, start, stop or timeout error.
- `tx_done`  out  1  1-cycle pulse, command accepted by device.
- `tx_err`  out  1  1-cycle pulse, command failed.

## Operation
- Both pad inputs pass through a 2-FF synchroniser. A falling edge (`fe`) is synced clock 1→0 between consecutive cycles.
- **IDLE**
  - `cmd_ready` = 1; both OEs = 0.
  - `fe` with data = 0 → RX.
  - Handshake → latch `cmd_byte`, compute odd parity → INHIBIT.
  - If both occur in the same cycle, RX wins and `cmd_ready` does not complete.
- **RX**
  - Sample data on each `fe`: 8 data bits LSB first, then parity, then stop.
  - On the stop bit, check odd parity over data+parity and stop = 1.
  - Good frame: update `rx_byte`, pulse `rx_valid`. Bad frame: pulse `rx_err`, leave `rx_byte` unchanged.
  - → IDLE.
- **INHIBIT**: `keyb_clk_oe` = 1 for `INHIBIT_CYCLES`. In the last cycle assert `keyb_data_oe` = 1 (start bit) → RTS.
- **RTS**: release the clock (`keyb_clk_oe` = 0) and keep data low. First `fe` → TX, bit index 0.
- **TX**
  - On each `fe`, drive the next bit: data bits 0..7, then parity, then stop.
  - Drive `keyb_data_oe` = ~bit. The stop bit is sent by releasing data.
  - After the stop bit → TX_ACK.
- **TX_ACK**: on the next `fe`, sample data.
  - 0 → line-level ACK; 1 → `tx_err`, IDLE.
  - Then wait for clock and data both high → IDLE, or → WAIT_RESP when the feature is enabled.
- **Timeout**: in RX, RTS, TX, TX_ACK and WAIT_RESP, an idle counter resets on every `fe`.
  - Reaching `TIMEOUT_CYCLES` releases both OEs and returns to IDLE.
  - Pulses `rx_err` if in RX, otherwise `tx_err`.
- **Reset** (`reset` = 0 at an edge)
  - Next cycle: state IDLE, both OEs 0, `rx_byte` 0x00, all pulses 0, counters 0.
  - `cmd_ready` is 1 once `reset` is high.
  - Applies mid-frame: any partial byte is discarded.

## Timing
- Pad change → `fe` seen 3 clk cycles later (2 sync + edge register).
- `rx_valid`/`rx_err` assert 1 cycle after the `fe` that samples the stop bit.
- TX data OE updates 1 cycle after `fe`, well inside the device's clock-low half period.
- `keyb_clk_oe` low time is exactly `INHIBIT_CYCLES` cycles.
- `keyb_data_oe` rises in the last inhibit cycle; the clock is released the following cycle.
- All pulse outputs last exactly 1 cycle.
- `cmd_ready` drops the cycle after the handshake.

## Configuration
- `PS2_HOST_ACK_WAIT_EN` defined:
  - After line ACK, enter WAIT_RESP and receive one full frame with RX rules.
  - 0xFA → `tx_done`. 0xFE, any other byte, a bad frame, or timeout → `tx_err`.
  - The response byte is not forwarded on `rx_valid`.
- Not defined:
  - `tx_done` pulses once both lines are high after a line-level ACK.
  - Any following device byte is handled as a normal RX frame.

## Test plan
- **Receive 0x16**: device sends 0x16, parity 0, stop 1 → one `rx_valid` pulse, `rx_byte` = 0x16, no `rx_err`.
- **Bad parity**: device sends 0x1E with parity 0 → `rx_err` pulse, `rx_byte` keeps its previous value, state returns to IDLE.
- **Transmit 0xED**: `cmd_valid` with 0xED → clock low for exactly 10000 cycles.
  - Device model then clocks in bits 1,0,1,1,0,1,1,1, parity 1, stop 1, ACK 0.
  - Result: `tx_done` pulse (macro off).
- **Ack wait, 0xFA**: with `PS2_HOST_ACK_WAIT_EN`, send 0xED and the device replies 0xFA → `tx_done` pulse, no `rx_valid`.
- **Ack wait, 0xFE**: same setup, device replies 0xFE → `tx_err` pulse.
- **Timeout**: device stops clocking after bit 3 of a TX → after 2000000 idle cycles, `tx_err` pulse, both OEs 0, `cmd_ready` = 1.
- **Mid-frame reset and arbitration**:
  - Assert `reset` = 0 during TX bit 5 → next cycle both OEs 0, state IDLE.
  - `cmd_valid` coinciding with a start-bit `fe` → frame is received and the command waits.

Source files
------------

// File: rtl/ps2_host_ctrl.sv
// PS/2 host line controller: receives device frames and sends host commands over one clock/data pair.
// Optional build macro PS2_HOST_ACK_WAIT_EN: after a line ACK, wait for the device's 0xFA/0xFE reply.
module ps2_host_ctrl #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyb_clk_in,
    input  logic       keyb_data_in,
    output logic       keyb_clk_oe,
    output logic       keyb_data_oe,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ready,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_err,
    output logic       tx_done,
    output logic       tx_err
);

`ifdef PS2_HOST_ACK_WAIT_EN
    localparam logic ACK_WAIT = 1'b1;
`else
    localparam logic ACK_WAIT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_INHIBIT,
        S_RTS,
        S_TX,
        S_TX_ACK,
        S_ACK_REL,
        S_WAIT_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        clk_s1_q, clk_s2_q, clk_prev_q;
    logic        data_s1_q, data_s2_q;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] cnt_q, cnt_d;
    logic [8:0]  rx_sh_q, rx_sh_d;
    logic [8:0]  tx_sh_q, tx_sh_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        resp_q, resp_d;
    logic        clk_oe_q, clk_oe_d;
    logic        data_oe_q, data_oe_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_err_q, rx_err_d;
    logic        tx_done_q, tx_done_d;
    logic        tx_err_q, tx_err_d;

    logic        fe;
    logic        rx_start;
    logic        timed;
    logic [9:0]  frame;
    logic        frame_ok;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= keyb_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= keyb_data_in;
            data_s2_q  <= data_s1_q;
        end
    end

    assign fe       = clk_prev_q & ~clk_s2_q;
    assign rx_start = fe & ~data_s2_q;

    // cmd_valid/cmd_ready: the byte moves on a rising clk edge where both are high; cmd_ready
    // is withheld in the cycle a device start bit is seen, so reception wins and the command waits.
    assign cmd_ready = reset & (state_q == S_IDLE) & ~rx_start;

    assign frame    = {data_s2_q, rx_sh_q};
    assign frame_ok = (^frame[8:0]) & frame[9];
    assign timed    = (state_q != S_IDLE) && (state_q != S_INHIBIT);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        rx_byte_d  = rx_byte_q;
        resp_d     = resp_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        tx_done_d  = 1'b0;
        tx_err_d   = 1'b0;

        if (timed) begin
            cnt_d = fe ? 32'd0 : cnt_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (rx_start) begin
                    state_d   = S_RX;
                    bit_cnt_d = 4'd0;
                    cnt_d     = 32'd0;
                    resp_d    = 1'b0;
                end else if (cmd_valid && cmd_ready) begin
                    tx_sh_d  = {~^cmd_byte, cmd_byte};
                    state_d  = S_INHIBIT;
                    cnt_d    = 32'd0;
                    clk_oe_d = 1'b1;
                end
            end
            S_RX: begin
                if (fe) begin
                    rx_sh_d   = frame[9:1];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_IDLE;
                        resp_d  = 1'b0;
                        if (resp_q) begin
                            tx_done_d = frame_ok & (frame[7:0] == 8'hFA);
                            tx_err_d  = ~(frame_ok & (frame[7:0] == 8'hFA));
                        end else if (frame_ok) begin
                            rx_byte_d  = frame[7:0];
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_err_d = 1'b1;
                        end
                    end
                end
            end
            S_INHIBIT: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == INHIBIT_CYCLES - 2) begin
                    data_oe_d = 1'b1;
                end
                if (cnt_q == INHIBIT_CYCLES - 1) begin
                    state_d  = S_RTS;
                    clk_oe_d = 1'b0;
                    cnt_d    = 32'd0;
                end
            end
            S_RTS: begin
                // The device's first falling edge asks for data bit 0.
                if (fe) begin
                    data_oe_d = ~tx_sh_q[0];
                    tx_sh_d   = {1'b1, tx_sh_q[8:1]};
                    bit_cnt_d = 4'd1;
                    state_d   = S_TX;
                end
            end
            S_TX: begin
                // A 1 is shifted in behind the parity bit, so bit 9 releases data as the stop bit.
                if (fe) begin
                    data_oe_d = ~tx_sh_q[0];
                    tx_sh_d   = {1'b1, tx_sh_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_TX_ACK;
                    end
                end
            end
            S_TX_ACK: begin
                if (fe) begin
                    if (!data_s2_q) begin
                        state_d = S_ACK_REL;
                    end else begin
                        state_d  = S_IDLE;
                        tx_err_d = 1'b1;
                    end
                end
            end
            S_ACK_REL: begin
                if (clk_s2_q && data_s2_q) begin
                    if (ACK_WAIT) begin
                        state_d = S_WAIT_RESP;
                        cnt_d   = 32'd0;
                    end else begin
                        state_d   = S_IDLE;
                        tx_done_d = 1'b1;
                    end
                end
            end
            S_WAIT_RESP: begin
                if (fe) begin
                    if (!data_s2_q) begin
                        state_d   = S_RX;
                        bit_cnt_d = 4'd0;
                        resp_d    = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                        tx_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timed && !fe && (cnt_q == TIMEOUT_CYCLES - 1)) begin
            state_d    = S_IDLE;
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
            cnt_d      = 32'd0;
            resp_d     = 1'b0;
            rx_valid_d = 1'b0;
            tx_done_d  = 1'b0;
            rx_err_d   = (state_q == S_RX) && !resp_q;
            tx_err_d   = !((state_q == S_RX) && !resp_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            cnt_q      <= 32'd0;
            rx_sh_q    <= 9'd0;
            tx_sh_q    <= 9'd0;
            rx_byte_q  <= 8'h00;
            resp_q     <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            rx_byte_q  <= rx_byte_d;
            resp_q     <= resp_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            tx_done_q  <= tx_done_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign keyb_clk_oe  = clk_oe_q;
    assign keyb_data_oe = data_oe_q;
    assign rx_valid     = rx_valid_q;
    assign rx_byte      = rx_byte_q;
    assign rx_err       = rx_err_q;
    assign tx_done      = tx_done_q;
    assign tx_err       = tx_err_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: open-drain device model, directed and random frames, pulse scoreboard.
module tb_ps2_host_ctrl;

    localparam int unsigned INH = 40;
    localparam int unsigned TO  = 600;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       keyb_clk_in, keyb_data_in;
    logic       keyb_clk_oe, keyb_data_oe;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_ready;
    logic       rx_valid, rx_err, tx_done, tx_err;
    logic [7:0] rx_byte;

    int checks = 0;
    int failures = 0;
    int n_rx_valid = 0, n_rx_err = 0, n_tx_done = 0, n_tx_err = 0;
    int e_rx_valid = 0, e_rx_err = 0, e_tx_done = 0, e_tx_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] exp_rx_byte = 8'h00;

    assign keyb_clk_in  = dev_clk & ~keyb_clk_oe;
    assign keyb_data_in = dev_data & ~keyb_data_oe;

    always #5 clk = ~clk;

    ps2_host_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .keyb_clk_in(keyb_clk_in), .keyb_data_in(keyb_data_in),
        .keyb_clk_oe(keyb_clk_oe), .keyb_data_oe(keyb_data_oe),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_err(rx_err),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            n_rx_valid++;
            obs_q.push_back(rx_byte);
        end
        if (rx_err)  n_rx_err++;
        if (tx_done) n_tx_done++;
        if (tx_err)  n_tx_err++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic odd_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        logic [7:0] e, o;
        chk({tag, "_rx_valid_cnt"}, n_rx_valid, e_rx_valid);
        chk({tag, "_rx_err_cnt"}, n_rx_err, e_rx_err);
        chk({tag, "_tx_done_cnt"}, n_tx_done, e_tx_done);
        chk({tag, "_tx_err_cnt"}, n_tx_err, e_tx_err);
        chk({tag, "_rx_byte"}, rx_byte, exp_rx_byte);
        chk({tag, "_rx_q_len"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_rx_data"}, o, e);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Device-to-host frame; with arb set, cmd_valid rises in the very cycle the start-bit edge is seen.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input bit arb, input logic [7:0] arb_byte);
        logic [10:0] f;
        f = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            dev_data = f[i];
            repeat (5) @(negedge clk);
            dev_clk = 1'b0;
            if (i == 0 && arb) begin
                repeat (2) @(negedge clk);
                cmd_byte  = arb_byte;
                cmd_valid = 1'b1;
                #1 chk("arb_ready_low", cmd_ready, 1'b0);
                repeat (13) @(negedge clk);
            end else begin
                repeat (15) @(negedge clk);
            end
            dev_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        dev_data = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic par, input logic stop, input string tag);
        send_frame(b, par, stop, 1'b0, 8'h00);
        if (par == odd_par(b) && stop) begin
            e_rx_valid++;
            exp_q.push_back(b);
            exp_rx_byte = b;
        end else begin
            e_rx_err++;
        end
        check_counts(tag);
    endtask

    task automatic send_cmd(input logic [7:0] b, output int inh, output int doe);
        int n;
        n = 0;
        inh = 0;
        doe = 0;
        @(negedge clk);
        cmd_byte  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_handshake", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_ready_drop", cmd_ready, 1'b0);
        while (keyb_clk_oe && inh < int'(INH) + 50) begin
            inh++;
            if (keyb_data_oe && doe == 0) doe = inh;
            @(negedge clk);
        end
        chk("rts_data_low", keyb_data_oe, 1'b1);
    endtask

    task automatic dev_clock_in(input int n, output logic [9:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dev_clk = 1'b0;
            repeat (15) @(negedge clk);
            got[i] = keyb_data_in;
            dev_clk = 1'b1;
            repeat (14) @(negedge clk);
        end
    endtask

    task automatic dev_ack(input logic ack);
        @(negedge clk);
        dev_data = ack;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (15) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic finish_tx(input logic [7:0] b, input logic ack, input logic [7:0] resp,
                             input string tag);
        logic [9:0] got;
        dev_clock_in(10, got);
        chk({tag, "_bits"}, got, {1'b1, odd_par(b), b});
        dev_ack(ack);
        if (ack) begin
            e_tx_err++;
        end else begin
`ifdef PS2_HOST_ACK_WAIT_EN
            send_frame(resp, odd_par(resp), 1'b1, 1'b0, 8'h00);
            if (resp == 8'hFA) e_tx_done++;
            else e_tx_err++;
`else
            e_tx_done++;
            send_frame(resp, odd_par(resp), 1'b1, 1'b0, 8'h00);
            e_rx_valid++;
            exp_q.push_back(resp);
            exp_rx_byte = resp;
`endif
        end
        repeat (10) @(negedge clk);
        check_counts(tag);
    endtask

    task automatic do_tx(input logic [7:0] b, input logic ack, input logic [7:0] resp,
                         input string tag);
        int inh, doe;
        send_cmd(b, inh, doe);
        chk({tag, "_inhibit_len"}, inh, INH);
        chk({tag, "_start_bit_at"}, doe, INH);
        finish_tx(b, ack, resp, tag);
    endtask

    initial begin
        int inh, doe, n, kind;
        logic [7:0] b, r;
        logic [9:0] got;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", keyb_clk_oe, 1'b0);
        chk("rst_data_oe", keyb_data_oe, 1'b0);
        chk("rst_cmd_ready_low", cmd_ready, 1'b0);
        chk("rst_pulses", {rx_valid, rx_err, tx_done, tx_err}, 4'b0000);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rx_byte", rx_byte, 8'h00);

        // Directed receive, then bad parity
        rx_frame(8'h16, 1'b0, 1'b1, "rx_16");
        rx_frame(8'h1E, 1'b0, 1'b1, "rx_bad_par");
        chk("bad_par_idle", cmd_ready, 1'b1);

        // Random receive frames with parity/stop corruption
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 3);
            rx_frame(b, (kind == 0) ? ~odd_par(b) : odd_par(b), (kind == 1) ? 1'b0 : 1'b1, "rx_rand");
        end

        // Directed and random transmit
        do_tx(8'hED, 1'b0, 8'hFA, "tx_ed");
`ifdef PS2_HOST_ACK_WAIT_EN
        do_tx(8'hED, 1'b0, 8'hFE, "tx_ed_fe");
`endif
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            r = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'($urandom_range(0, 255));
            do_tx(b, 1'b0, r, "tx_rand");
        end
        do_tx(8'h55, 1'b1, 8'h00, "tx_nack");

        // Device stops clocking after bit 3
        send_cmd(8'hA5, inh, doe);
        dev_clock_in(4, got);
        n = 0;
        while (n_tx_err == e_tx_err && n < int'(TO) + 200) begin
            @(negedge clk);
            n++;
        end
        e_tx_err++;
        @(negedge clk);
        chk("timeout_window", (n >= int'(TO) - 40) && (n <= int'(TO) - 10), 1'b1);
        chk("timeout_oes", {keyb_clk_oe, keyb_data_oe}, 2'b00);
        chk("timeout_cmd_ready", cmd_ready, 1'b1);
        check_counts("timeout");

        // Reset during TX bit 5 (0x1C has bit 5 = 0, so data is being pulled low)
        send_cmd(8'h1C, inh, doe);
        dev_clock_in(6, got);
        chk("midrst_data_low", keyb_data_oe, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_oes", {keyb_clk_oe, keyb_data_oe}, 2'b00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_rx_byte = 8'h00;
        @(negedge clk);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        check_counts("midrst");
        rx_frame(8'h3C, odd_par(8'h3C), 1'b1, "post_rst_rx");

        // Command offered on the same cycle as a start-bit edge
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b1, 8'hF0);
        e_rx_valid++;
        exp_q.push_back(8'h5A);
        exp_rx_byte = 8'h5A;
        chk("arb_cmd_started", keyb_clk_oe, 1'b1);
        cmd_valid = 1'b0;
        n = 0;
        while (keyb_clk_oe && n < int'(INH) + 50) begin
            @(negedge clk);
            n++;
        end
        chk("arb_rts", {keyb_clk_oe, keyb_data_oe}, 2'b01);
        finish_tx(8'hF0, 1'b0, 8'hFA, "arb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
